vga_mode_sequencer: RTL

//  Glitch-free resolution-change controller for the four-mode display top (VGA/SVGA/XGA/VESA

---
 rtl/vga_mode_pkg.sv | 21 ++
 rtl/vga_mode_sequencer_toggle_sync.sv | 29 ++
 rtl/vga_mode_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_mode_pkg.sv
// Shared mode encodings, FSM state type and counter widths for the
// resolution-change sequencer.
package vga_mode_pkg;

    localparam logic [1:0] MODE_VGA  = 2'd0;
    localparam logic [1:0] MODE_SVGA = 2'd1;
    localparam logic [1:0] MODE_XGA  = 2'd2;
    localparam logic [1:0] MODE_VESA = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        BLANK  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int DCNT_W = 20;
    localparam int TCNT_W = 22;
    localparam int FCNT_W = 4;

endpackage

// File: rtl/vga_mode_sequencer_toggle_sync.sv
// Brings one frame toggle from a pixel-clock domain into clk and turns each
// toggle into a single-cycle pulse.
module toggle_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_toggle,
    output logic o_pulse
);

    logic r_sync_p0;
    logic r_sync_p1;
    logic r_edge_p2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_edge_p2 <= 1'b0;
        end else begin
            r_sync_p0 <= i_toggle;
            r_sync_p1 <= r_sync_p0;
            r_edge_p2 <= r_sync_p1;
        end
    end

    // Any level change after the synchronizer is one frame
    assign o_pulse = r_sync_p1 ^ r_edge_p2;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Glitch-free resolution-change controller: debounces the mode switches and
// moves the output mux select only on frame boundaries, behind a forced blank.
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw,
    input  logic [3:0] frame_toggle,
    output logic [1:0] rez,
    output logic       blank,
    output logic       busy,
    output logic       switch_err
);

    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_blank_frames_check
        $error("vga_mode_sequencer: BLANK_FRAMES must be within 1..15");
    end

    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_END = FCNT_W'(BLANK_FRAMES);

    logic [3:0] w_pulse;

    for (genvar g = 0; g < 4; g++) begin : g_frame_sync
        toggle_sync u_toggle_sync (
            .i_clk    (clk),
            .i_reset  (reset),
            .i_toggle (frame_toggle[g]),
            .o_pulse  (w_pulse[g])
        );
    end

    // Switch synchronizer and debouncer
    logic [1:0]        r_sw_p0;
    logic [1:0]        r_sw_p1;
    logic [1:0]        r_cand;
    logic [DCNT_W-1:0] r_dcnt;
    logic [1:0]        r_sw_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_p0     <= 2'd0;
            r_sw_p1     <= 2'd0;
            r_cand      <= 2'd0;
            r_dcnt      <= '0;
            r_sw_stable <= 2'd0;
        end else begin
            r_sw_p0 <= sw;
            r_sw_p1 <= r_sw_p0;
            if (r_sw_p1 != r_cand) begin
                r_cand <= r_sw_p1;
                r_dcnt <= '0;
            end else if (r_dcnt != DCNT_MAX) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else begin
                r_sw_stable <= r_cand;
            end
        end
    end

    // Sequencer FSM and its registered outputs
    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rez;
    logic              r_blank;
    logic              r_busy;
    logic              r_err;
    logic [1:0]        r_target;
    logic [FCNT_W-1:0] r_fcnt;
    logic [TCNT_W-1:0] r_tcnt;

    logic [1:0]        w_rez_nxt;
    logic              w_blank_nxt;
    logic              w_busy_nxt;
    logic              w_err_nxt;
    logic [1:0]        w_target_nxt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [TCNT_W-1:0] w_tcnt_nxt;

    logic              w_pulse_rez;
    logic              w_tmo;
    logic              w_evt;
    logic [FCNT_W-1:0] w_fcnt_inc;

    assign w_pulse_rez = w_pulse[r_rez];
    assign w_tmo       = (r_state != IDLE) && (r_tcnt == TCNT_MAX);
    // A pulse and a timeout in the same cycle are a single event
    assign w_evt       = w_pulse_rez | w_tmo;
    assign w_fcnt_inc  = r_fcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SETTLE;
            r_rez    <= MODE_VGA;
            r_blank  <= 1'b1;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
            r_target <= MODE_VGA;
            r_fcnt   <= '0;
            r_tcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rez    <= w_rez_nxt;
            r_blank  <= w_blank_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
            r_target <= w_target_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_sw_stable != r_rez) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_sw_stable == r_rez) w_state_nxt = IDLE;
                else if (w_evt)           w_state_nxt = BLANK;
            end
            BLANK: begin
                if (w_evt && (w_fcnt_inc == FCNT_END)) w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (w_evt) w_state_nxt = IDLE;
            end
            default: w_state_nxt = SETTLE;
        endcase
    end

    always_comb begin
        w_rez_nxt    = r_rez;
        w_blank_nxt  = r_blank;
        w_busy_nxt   = (w_state_nxt != IDLE);
        w_err_nxt    = r_err | w_tmo;
        w_target_nxt = r_target;
        w_fcnt_nxt   = r_fcnt;
        w_tcnt_nxt   = r_tcnt + 1'b1;

        // The wait timer restarts on every state entry and every accepted event
        if (r_state == IDLE || w_state_nxt != r_state || w_evt) begin
            w_tcnt_nxt = '0;
        end

        case (r_state)
            IDLE: begin
                if (r_sw_stable != r_rez) w_target_nxt = r_sw_stable;
            end
            DRAIN: begin
                w_target_nxt = r_sw_stable;
                if ((r_sw_stable != r_rez) && w_evt) begin
                    w_blank_nxt = 1'b1;
                    w_fcnt_nxt  = '0;
                end
            end
            BLANK: begin
                if (w_evt) begin
                    w_fcnt_nxt = w_fcnt_inc;
                    if (w_fcnt_inc == FCNT_END) w_rez_nxt = r_target;
                end
            end
            SETTLE: begin
                if (w_evt) w_blank_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    assign rez        = r_rez;
    assign blank      = r_blank;
    assign busy       = r_busy;
    assign switch_err = r_err;

endmodule
